// File: rtl/gf_2ton_koa_splitter_pipe.sv
// Karatsuba operand splitter for GF(2^n) multipliers.
// Each level splits every (x, y) pair into three half-width pairs:
// lo halves, lo^hi, hi halves. NB_LEVELS levels are applied in sequence.
// Build option: define GF_KOA_SPLITTER_STAGE_REG_EN to register every level
// (latency NB_LEVELS). Otherwise all levels are combinational and feed a
// single output register (latency 1). The ready/valid handshake is the same
// in both builds.
module gf_2ton_koa_splitter_pipe #(
    parameter  int NB_DATA   = 128,
    parameter  int NB_LEVELS = 2,
    localparam int NB_SUB    = NB_DATA / (2 ** NB_LEVELS),
    localparam int NB_OUT    = (3 ** NB_LEVELS) * 2 * NB_SUB
) (
    input  logic                 i_clock,
    input  logic                 i_reset_n,
    input  logic [2*NB_DATA-1:0] i_data_bus,
    input  logic                 i_valid,
    output logic                 o_ready,
    output logic [NB_OUT-1:0]    o_data_bus,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_busy
);

    localparam int NSLOT   = 3 ** NB_LEVELS;
    localparam int NB_HALF = NSLOT * NB_SUB;
`ifdef GF_KOA_SPLITTER_STAGE_REG_EN
    localparam int NST = NB_LEVELS;
`else
    localparam int NST = 1;
`endif

    if (NB_LEVELS < 1 || NB_LEVELS > 3) begin : g_bad_levels
        $error("NB_LEVELS must be in 1..3");
    end
    if (NB_DATA % (2 ** NB_LEVELS) != 0) begin : g_bad_width
        $error("NB_DATA must be divisible by 2**NB_LEVELS");
    end

    logic [NST-1:0] vld_q;
    logic [NST-1:0] vld_d;
    logic [NST-1:0] ld;
    logic [NST-1:0] vin;

    // Load enables: a stage loads when it is empty or everything after it can move.
    always_comb begin
        logic acc;
        acc = i_ready;
        ld  = '0;
        vin = '0;
        for (int s = NST - 1; s >= 0; s--) begin
            acc   = acc | ~vld_q[s];
            ld[s] = acc;
        end
        vin[0] = i_valid;
        for (int s = 1; s < NST; s++) begin
            vin[s] = vld_q[s-1];
        end
        vld_d = (ld & vin) | (~ld & vld_q);
    end

    // Stage valid flags; cleared immediately by reset so in-flight vectors vanish.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) vld_q <= '0;
        else            vld_q <= vld_d;
    end

    assign o_ready = ld[0];
    assign o_valid = vld_q[NST-1];
    assign o_busy  = |vld_q;

    for (genvar k = 0; k < NB_LEVELS; k++) begin : g_lvl
        localparam int NI = 3 ** k;
        localparam int WI = NB_DATA >> k;
        localparam int WO = WI / 2;

        logic [NI*WI-1:0]   x_in,  y_in;
        logic [3*NI*WO-1:0] x_sp,  y_sp;
        logic [3*NI*WO-1:0] x_st,  y_st;

        if (k == 0) begin : g_src
            assign x_in = i_data_bus[NB_DATA-1:0];
            assign y_in = i_data_bus[2*NB_DATA-1:NB_DATA];
        end else begin : g_src
            assign x_in = g_lvl[k-1].x_st;
            assign y_in = g_lvl[k-1].y_st;
        end

        // Split pair j into slots 3j (lo), 3j+1 (lo^hi), 3j+2 (hi).
        always_comb begin
            x_sp = '0;
            y_sp = '0;
            for (int j = 0; j < NI; j++) begin
                x_sp[(3*j)*WO   +: WO] = x_in[j*WI +: WO];
                x_sp[(3*j+1)*WO +: WO] = x_in[j*WI +: WO] ^ x_in[j*WI+WO +: WO];
                x_sp[(3*j+2)*WO +: WO] = x_in[j*WI+WO +: WO];
                y_sp[(3*j)*WO   +: WO] = y_in[j*WI +: WO];
                y_sp[(3*j+1)*WO +: WO] = y_in[j*WI +: WO] ^ y_in[j*WI+WO +: WO];
                y_sp[(3*j+2)*WO +: WO] = y_in[j*WI+WO +: WO];
            end
        end

`ifdef GF_KOA_SPLITTER_STAGE_REG_EN
        logic [3*NI*WO-1:0] x_q, y_q;

        // Level register, loaded only when this stage accepts a valid vector.
        always_ff @(posedge i_clock or negedge i_reset_n) begin
            if (!i_reset_n) begin
                x_q <= '0;
                y_q <= '0;
            end else if (ld[k] && vin[k]) begin
                x_q <= x_sp;
                y_q <= y_sp;
            end
        end

        assign x_st = x_q;
        assign y_st = y_q;
`else
        assign x_st = x_sp;
        assign y_st = y_sp;
`endif
    end

    logic [NB_HALF-1:0] x_fin, y_fin;

`ifdef GF_KOA_SPLITTER_STAGE_REG_EN
    assign x_fin = g_lvl[NB_LEVELS-1].x_st;
    assign y_fin = g_lvl[NB_LEVELS-1].y_st;
`else
    logic [NB_HALF-1:0] x_out_q, y_out_q;

    // Single output register capturing the fully split vector on acceptance.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            x_out_q <= '0;
            y_out_q <= '0;
        end else if (ld[0] && vin[0]) begin
            x_out_q <= g_lvl[NB_LEVELS-1].x_st;
            y_out_q <= g_lvl[NB_LEVELS-1].y_st;
        end
    end

    assign x_fin = x_out_q;
    assign y_fin = y_out_q;
`endif

    for (genvar s = 0; s < NSLOT; s++) begin : g_pack
        assign o_data_bus[s*2*NB_SUB +: 2*NB_SUB] =
            {y_fin[s*NB_SUB +: NB_SUB], x_fin[s*NB_SUB +: NB_SUB]};
    end

endmodule

// File: tb/tb_gf_2ton_koa_splitter_pipe.sv
// Self-checking bench for gf_2ton_koa_splitter_pipe (default parameters).
module tb_gf_2ton_koa_splitter_pipe;

    localparam int NB_DATA   = 128;
    localparam int NB_LEVELS = 2;
    localparam int NB_SUB    = NB_DATA / (2 ** NB_LEVELS);
    localparam int NSLOT     = 3 ** NB_LEVELS;
    localparam int NCHUNK    = 2 ** NB_LEVELS;
    localparam int NB_HALF   = NSLOT * NB_SUB;
    localparam int NB_OUT    = 2 * NB_HALF;
`ifdef GF_KOA_SPLITTER_STAGE_REG_EN
    localparam int LAT = NB_LEVELS;
`else
    localparam int LAT = 1;
`endif

    logic                 clk = 1'b0;
    logic                 i_reset_n;
    logic [2*NB_DATA-1:0] i_data_bus;
    logic                 i_valid;
    logic                 o_ready;
    logic [NB_OUT-1:0]    o_data_bus;
    logic                 o_valid;
    logic                 i_ready;
    logic                 o_busy;

    gf_2ton_koa_splitter_pipe #(
        .NB_DATA   (NB_DATA),
        .NB_LEVELS (NB_LEVELS)
    ) dut (
        .i_clock    (clk),
        .i_reset_n  (i_reset_n),
        .i_data_bus (i_data_bus),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .o_data_bus (o_data_bus),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_busy     (o_busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int first_ov = -1;
    int in_cnt  = 0;
    int out_cnt = 0;
    bit b2b = 1'b0;
    bit hold_prev = 1'b0;
    logic [NB_OUT-1:0] prev_data;
    logic [NB_OUT-1:0] first_out;
    logic [NB_OUT-1:0] q[$];

    task automatic chk(input string tag, input logic [NB_OUT-1:0] act,
                       input logic [NB_OUT-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    // Slot s is the XOR of every NB_SUB chunk whose per-level half choice
    // agrees with the base-3 digits of s (0 = lo, 2 = hi, 1 = both).
    function automatic logic [NB_HALF-1:0] split_ref(input logic [NB_DATA-1:0] v);
        logic [NB_HALF-1:0] r;
        logic [NB_SUB-1:0]  acc;
        bit ok;
        int t, d, b;
        r = '0;
        for (int s = 0; s < NSLOT; s++) begin
            acc = '0;
            for (int c = 0; c < NCHUNK; c++) begin
                ok = 1'b1;
                t  = s;
                for (int p = 0; p < NB_LEVELS; p++) begin
                    d = t % 3;
                    t = t / 3;
                    b = (c >> p) & 1;
                    if ((d == 0 && b == 1) || (d == 2 && b == 0)) ok = 1'b0;
                end
                if (ok) acc = acc ^ v[c*NB_SUB +: NB_SUB];
            end
            r[s*NB_SUB +: NB_SUB] = acc;
        end
        return r;
    endfunction

    function automatic logic [NB_OUT-1:0] ref_out(input logic [2*NB_DATA-1:0] din);
        logic [NB_HALF-1:0] rx, ry;
        logic [NB_OUT-1:0]  o;
        rx = split_ref(din[NB_DATA-1:0]);
        ry = split_ref(din[2*NB_DATA-1:NB_DATA]);
        o  = '0;
        for (int s = 0; s < NSLOT; s++) begin
            o[s*2*NB_SUB +: 2*NB_SUB] = {ry[s*NB_SUB +: NB_SUB], rx[s*NB_SUB +: NB_SUB]};
        end
        return o;
    endfunction

    task automatic rand_data();
        for (int i = 0; i < 2 * NB_DATA / 32; i++) i_data_bus[i*32 +: 32] = $urandom;
        if ($urandom_range(0, 15) == 0) i_data_bus = '1;
    endtask

    // One clock: observe at the falling edge, update the scoreboard, return after the rising edge.
    task automatic cycle();
        @(negedge clk);
        cyc++;
        chk("busy", NB_OUT'(o_busy), NB_OUT'(q.size() != 0));
        if (q.size() == 0) chk("rdy_empty", NB_OUT'(o_ready), NB_OUT'(1));
        if (b2b) chk("b2b_rdy", NB_OUT'(o_ready), NB_OUT'(1));
        if (hold_prev) begin
            chk("hold_vld", NB_OUT'(o_valid), NB_OUT'(1));
            chk("hold_data", o_data_bus, prev_data);
        end
        if (o_valid) begin
            if (first_ov < 0) begin
                first_ov  = cyc;
                first_out = o_data_bus;
            end
            if (q.size() == 0) chk("spurious", NB_OUT'(o_valid), NB_OUT'(0));
            else               chk("data", o_data_bus, q[0]);
        end
        hold_prev = o_valid && !i_ready;
        prev_data = o_data_bus;
        if (o_valid && i_ready && q.size() != 0) begin
            void'(q.pop_front());
            out_cnt++;
        end
        if (i_valid && o_ready) begin
            q.push_back(ref_out(i_data_bus));
            in_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int c0;
        int out0;
        i_reset_n  = 1'b0;
        i_valid    = 1'b0;
        i_ready    = 1'b0;
        i_data_bus = '0;
        #12;
        chk("rst_vld",  NB_OUT'(o_valid), NB_OUT'(0));
        chk("rst_busy", NB_OUT'(o_busy),  NB_OUT'(0));
        chk("rst_rdy",  NB_OUT'(o_ready), NB_OUT'(1));
        chk("rst_data", o_data_bus, '0);
        @(posedge clk);
        #1;
        i_reset_n = 1'b1;

        // Directed quarter pattern and latency
        i_ready    = 1'b1;
        i_valid    = 1'b1;
        i_data_bus = '0;
        i_data_bus[NB_DATA-1:0] = {32'h1, 32'h2, 32'h4, 32'h8};
        first_ov = -1;
        cycle();
        c0 = cyc;
        i_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (first_ov >= 0) break;
        end
        chk("latency", NB_OUT'(first_ov - c0), NB_OUT'(LAT));
        chk("slot4_x", NB_OUT'(first_out[4*2*NB_SUB +: NB_SUB]), NB_OUT'(32'hF));
        chk("slot0_x", NB_OUT'(first_out[0 +: NB_SUB]),          NB_OUT'(32'h8));
        chk("slot8_x", NB_OUT'(first_out[8*2*NB_SUB +: NB_SUB]), NB_OUT'(32'h1));
        chk("slot4_y", NB_OUT'(first_out[4*2*NB_SUB+NB_SUB +: NB_SUB]), NB_OUT'(0));

        // Back-to-back random vectors with the sink always ready
        out0 = out_cnt;
        b2b  = 1'b1;
        i_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            rand_data();
            cycle();
        end
        b2b = 1'b0;
        i_valid = 1'b0;
        repeat (LAT + 3) cycle();
        chk("b2b_count", NB_OUT'(out_cnt - out0), NB_OUT'(100));

        // Backpressure: fill the pipe, then hold the sink off
        i_ready = 1'b0;
        i_valid = 1'b1;
        for (int i = 0; i < LAT + 5; i++) begin
            rand_data();
            cycle();
        end
        @(negedge clk);
        chk("full_nordy", NB_OUT'(o_ready), NB_OUT'(0));
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_ready = 1'b1;
        repeat (LAT + 3) cycle();
        chk("bp_lossless", NB_OUT'(out_cnt), NB_OUT'(in_cnt));

        // Reset with vectors in flight
        i_ready = 1'b0;
        i_valid = 1'b1;
        rand_data();
        cycle();
        rand_data();
        cycle();
        i_valid = 1'b0;
        @(negedge clk);
        i_reset_n = 1'b0;
        #1;
        chk("mid_rst_vld",  NB_OUT'(o_valid), NB_OUT'(0));
        chk("mid_rst_busy", NB_OUT'(o_busy),  NB_OUT'(0));
        chk("mid_rst_rdy",  NB_OUT'(o_ready), NB_OUT'(1));
        chk("mid_rst_data", o_data_bus, '0);
        q.delete();
        hold_prev = 1'b0;
        @(posedge clk);
        #1;
        i_reset_n = 1'b1;
        i_ready   = 1'b1;
        repeat (LAT + 4) cycle();

        // Random valid/ready toggling
        in_cnt  = 0;
        out_cnt = 0;
        for (int i = 0; i < 10000; i++) begin
            i_valid = ($urandom_range(0, 3) != 0);
            i_ready = ($urandom_range(0, 3) != 0);
            rand_data();
            cycle();
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        repeat (LAT + 3) cycle();
        chk("rand_lossless", NB_OUT'(out_cnt), NB_OUT'(in_cnt));
        chk("rand_drained",  NB_OUT'(q.size()), NB_OUT'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gf_2ton_koa_splitter_pipe.md
GF_2TON_KOA_SPLITTER_PIPE -- requirements
Module: gf_2toN_koa_splitter_pipe

Interface
REQ-001 SHALL have parameter NB_DATA, default 128, meaning operand width in bits.
REQ-002 SHALL have parameter NB_LEVELS, default 2, meaning Karatsuba recursion depth, legal range 1..3.
REQ-003 SHALL derive local NB_SUB = NB_DATA/2^NB_LEVELS and NB_OUT = 3^NB_LEVELS*2*NB_SUB; elaboration SHALL fail if NB_DATA is not divisible by 2^NB_LEVELS.
REQ-004 SHALL have i_clock  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have i_reset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have i_data_bus  input  2*NB_DATA  operands: x in [NB_DATA-1:0], y in [2*NB_DATA-1:NB_DATA].
REQ-007 SHALL have i_valid  input  1  upstream data valid.
REQ-008 SHALL have o_ready  output  1  module accepts i_data_bus this cycle.
REQ-009 SHALL have o_data_bus  output  NB_OUT  3^NB_LEVELS sub-operand pairs; slot s at [s*2*NB_SUB +: 2*NB_SUB], packed {y_part, x_part}.
REQ-010 SHALL have o_valid  output  1  o_data_bus valid.
REQ-011 SHALL have i_ready  input  1  downstream accepts o_data_bus.
REQ-012 SHALL have o_busy  output  1  high while any pipeline stage holds valid data.

Function
REQ-013 Each level SHALL map pair j (halves lo/hi of width W/2) to slots 3j+0 = lo halves, 3j+1 = lo^hi, 3j+2 = hi halves, for x and y independently.
REQ-014 Level k+1 SHALL take level-k slots in ascending index order as its input pairs.
REQ-015 Transfer in SHALL occur when i_valid && o_ready; transfer out SHALL occur when o_valid && i_ready.
REQ-016 Each stage register SHALL load when its valid flag is low or the next stage (or i_ready for the last) accepts; o_ready SHALL equal the first-stage load condition.
REQ-017 o_ready SHALL be high when the pipeline is empty, independent of i_ready.
REQ-018 While o_valid && !i_ready, o_data_bus and o_valid SHALL remain stable.
REQ-019 Sustained i_valid and i_ready high SHALL give one vector per cycle with no bubbles.
REQ-020 Vectors SHALL exit in acceptance order; none dropped or duplicated.
REQ-021 o_busy SHALL be the OR of all stage valid flags.
REQ-022 Data registers SHALL not load when the associated stage is not accepting (clock-enable on load condition).

Reset
REQ-023 On i_reset_n low, all stage valid flags, o_valid, o_busy SHALL clear immediately and o_data_bus SHALL be zero.
REQ-024 Reset mid-operation SHALL discard all in-flight vectors; first acceptance possible the first rising edge after deassertion.
REQ-025 o_ready SHALL be high during and after reset (pipeline empty).

Configuration
REQ-026 Macro GF_KOA_SPLITTER_STAGE_REG_EN defined: one register stage per level, acceptance-to-o_valid latency NB_LEVELS cycles.
REQ-027 Macro undefined: all levels combinational, single output register, latency 1 cycle; handshake rules unchanged.

Verification
REQ-028 NB_LEVELS=1, x=128'h00000000000000FF_0000000000000F0F, y=0 -> after 1 cycle slot0 x=64'hF0F, slot1 x=64'hFF0, slot2 x=64'hFF, all y parts 0.
REQ-029 NB_LEVELS=2, x quarters q3..q0=32'h1,32'h2,32'h4,32'h8, y=0 -> slot4 x=32'hF, slot0 x=32'h8, slot8 x=32'h1; latency 2 with macro, 1 without.
REQ-030 100 random back-to-back vectors, i_ready=1 -> 100 outputs, matching golden model, o_ready never low.
REQ-031 Fill pipeline, hold i_ready=0 for 5 cycles -> o_data_bus stable, o_ready low once all stages full, no loss after release.
REQ-032 Assert i_reset_n low with 2 vectors in flight -> o_valid, o_busy 0 and o_data_bus 0 same cycle; neither vector appears after reset.
REQ-033 Random i_valid/i_ready toggling 10k cycles -> in-order, lossless output equal to golden model; o_busy low only when empty.
